// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width, iteration count and state type for the 16-bit divider
package div_pkg;

  localparam int DIV_W     = 16;
  localparam int DIV_ITERS = 16;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement negation at data width (also maps 0x8000 onto itself).
  function automatic logic [DIV_W-1:0] neg_w(input logic [DIV_W-1:0] x);
    return ~x + DIV_W'(1);
  endfunction

endpackage

// File: rtl/div_16b_if.sv
// rtl/div_16b_if.sv - request/result bundle between a divide requester and div_16b
interface div_16b_if;
  import div_pkg::*;

  logic             start;
  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [DIV_W-1:0] quotient;
  logic [DIV_W-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/sub_17b.sv
// rtl/sub_17b.sv - combinational 17-bit parallel-prefix borrow-lookahead subtractor (a - b)
module sub_17b (
  input  logic [16:0] a,
  input  logic [16:0] b,
  output logic [16:0] diff,
  output logic        borrow
);

  logic [16:0] gen;
  logic [16:0] prop;
  logic [16:0] grp_g;
  logic [16:0] grp_p;

  assign gen  = ~a & b;
  assign prop = ~(a ^ b);

  // Kogge-Stone prefix: grp_g[i] is the borrow out of bits [i:0]; walking i downward
  // keeps each level reading only the previous level's values.
  always_comb begin
    grp_g = gen;
    grp_p = prop;
    for (int d = 1; d < 17; d = d * 2) begin
      for (int i = 16; i >= d; i--) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
        grp_p[i] = grp_p[i] & grp_p[i-d];
      end
    end
  end

  assign diff   = a ^ b ^ {grp_g[15:0], 1'b0};
  assign borrow = grp_g[16];

endmodule

// File: rtl/div_16b.sv
// rtl/div_16b.sv - 16-bit restoring divider, one quotient bit per cycle; DIV_SIGNED_EN selects signed operands
module div_16b
  import div_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  div_16b_if.slave  bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] rem_r;
  logic [DIV_W-1:0] quo_r;
  logic [DIV_W-1:0] dvs_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;
  logic [DIV_W-1:0] quotient_r;
  logic [DIV_W-1:0] remainder_r;

  logic [DIV_W:0]   trial_a;
  logic [DIV_W:0]   trial_b;
  logic [DIV_W:0]   trial_d;
  logic             trial_borrow;
  logic             diff_unused;
  logic [DIV_W-1:0] step_rem;
  logic [DIV_W-1:0] step_quo;
  logic [DIV_W-1:0] op_a;
  logic [DIV_W-1:0] op_b;
  logic [DIV_W-1:0] res_q;
  logic [DIV_W-1:0] res_r;

  // Shifted partial remainder (17 bits so a divisor >= 0x8000 never loses the top bit).
  assign trial_a = {rem_r, quo_r[DIV_W-1]};
  assign trial_b = {1'b0, dvs_r};

  sub_17b u_sub (
    .a      (trial_a),
    .b      (trial_b),
    .diff   (trial_d),
    .borrow (trial_borrow)
  );

  // A kept difference is always below the divisor, so its top bit is zero.
  assign diff_unused = trial_d[DIV_W];
  assign step_rem    = trial_borrow ? trial_a[DIV_W-1:0] : trial_d[DIV_W-1:0];
  assign step_quo    = {quo_r[DIV_W-2:0], ~trial_borrow};

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Magnitudes go into the unsigned core; signs are re-applied on the way to DONE.
  assign op_a  = bus.dividend[DIV_W-1] ? neg_w(bus.dividend) : bus.dividend;
  assign op_b  = bus.divisor[DIV_W-1]  ? neg_w(bus.divisor)  : bus.divisor;
  assign res_q = neg_q ? neg_w(step_quo) : step_quo;
  assign res_r = neg_r ? neg_w(step_rem) : step_rem;

  // Operand signs captured on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      neg_q <= bus.dividend[DIV_W-1] ^ bus.divisor[DIV_W-1];
      neg_r <= bus.dividend[DIV_W-1];
    end
  end
`else
  assign op_a  = bus.dividend;
  assign op_b  = bus.divisor;
  assign res_q = step_quo;
  assign res_r = step_rem;
`endif

  // Control FSM with the iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvs_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            if (bus.divisor == '0) begin
              state       <= DONE;
              done_r      <= 1'b1;
              dbz_r       <= 1'b1;
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
            end else begin
              state  <= CALC;
              busy_r <= 1'b1;
              dbz_r  <= 1'b0;
              cnt    <= '0;
              rem_r  <= '0;
              quo_r  <= op_a;
              dvs_r  <= op_b;
            end
          end
        end
        CALC: begin
          rem_r <= step_rem;
          quo_r <= step_quo;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIV_ITERS - 1)) begin
            state       <= DONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            quotient_r  <= res_q;
            remainder_r <= res_r;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;

endmodule

// File: doc/div_16b.md
DIV_16B -- requirements
Module: div_16b

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-004 SHALL have port dividend, input, 16 bits: numerator, captured on the accepting edge.
REQ-005 SHALL have port divisor, input, 16 bits: denominator, captured on the accepting edge.
REQ-006 SHALL have port busy, output, 1 bit: high while in CALC.
REQ-007 SHALL have port done, output, 1 bit: single-cycle pulse when a result is valid.
REQ-008 SHALL have port quotient, output, 16 bits: result quotient.
REQ-009 SHALL have port remainder, output, 16 bits: result remainder.
REQ-010 SHALL have port div_by_zero, output, 1 bit: set with done when the captured divisor is 0.

Function
REQ-011 SHALL implement the FSM states IDLE, CALC and DONE; DONE lasts exactly one cycle and then returns to IDLE.
REQ-012 SHALL, when start=1 in IDLE with divisor!=0, capture the operands, enter CALC, clear div_by_zero and set busy.
REQ-013 SHALL perform restoring division in CALC, one quotient bit per cycle, MSB first: shift {rem,quo} left one bit, trial-subtract the divisor, and keep the difference (setting quo bit 1) iff there is no borrow.
REQ-014 SHALL use a 17-bit trial subtraction so that no borrow or overflow is lost for divisors of 0x8000 or above.
REQ-015 SHALL run exactly 16 CALC cycles; done is high during the cycle following the 16th rising edge after the accepting edge.
REQ-016 SHALL, when start=1 in IDLE with divisor==0, go directly to DONE with done=1 one edge later, div_by_zero=1, quotient=0xFFFF and remainder=dividend.
REQ-017 SHALL ignore start while in CALC or DONE; operand changes during CALC SHALL have no effect.
REQ-018 SHALL hold quotient, remainder and div_by_zero stable from DONE until the next accepted start.
REQ-019 SHALL allow back-to-back operation: start asserted in the IDLE cycle right after DONE is accepted.
REQ-020 SHALL keep busy and done mutually exclusive.

Reset
REQ-021 SHALL, on rst_n=0 at any time including mid-CALC, force state to IDLE and set busy=0, done=0, div_by_zero=0, quotient=0 and remainder=0 without waiting for clk.
REQ-022 SHALL accept start no earlier than the first rising edge after rst_n deasserts, and that edge SHALL accept it.

Configuration
REQ-023 SHALL, when DIV_SIGNED_EN is defined, treat operands as two's complement: divide the magnitudes, negate the quotient if the operand signs differ, and give the remainder the dividend's sign (truncation toward zero).
REQ-024 SHALL, with DIV_SIGNED_EN defined, produce quotient=0x8000 and remainder=0 for 0x8000/0xFFFF, and keep the latency of REQ-015 unchanged (sign fix-up is folded into the entry and DONE transitions).
REQ-025 SHALL, when DIV_SIGNED_EN is undefined, treat operands as unsigned only and omit the sign logic entirely.
REQ-026 SHALL apply REQ-016 identically in both builds.

Structure
REQ-027 SHALL take from the shared package div_pkg: the data width constant DIV_W=16, the iteration count DIV_ITERS=16, and the state enum (IDLE/CALC/DONE).
REQ-028 SHALL instantiate one sub-module, sub_17b, a combinational 17-bit borrow-lookahead subtractor that outputs the difference and the borrow, used for the trial step.
REQ-029 SHALL contain no other sub-modules; the counter, FSM and shift registers are local.

Verification
REQ-030 SHALL be verified with: unsigned 100/7 -> done after 16 edges, quotient=14, remainder=2, div_by_zero=0, busy high for 16 cycles.
REQ-031 SHALL be verified with: 0xFFFF/0x0001 -> quotient=0xFFFF, remainder=0; then 0x1234/0x8000 -> quotient=0, remainder=0x1234.
REQ-032 SHALL be verified with: 5/0 -> done one edge after start, div_by_zero=1, quotient=0xFFFF, remainder=5; busy never high.
REQ-033 SHALL be verified with: start pulsed again at CALC cycle 5 with different operands -> ignored, and the first result is unchanged.
REQ-034 SHALL be verified with: rst_n pulled low at CALC cycle 8 -> all outputs 0 immediately and state IDLE; a new 9/3 afterwards -> quotient=3, remainder=0.
REQ-035 SHALL be verified with: DIV_SIGNED_EN build, 0xFFF9/0x0002 (-7/2) -> quotient=0xFFFD, remainder=0xFFFF; 0x8000/0xFFFF -> quotient=0x8000, remainder=0.
